// File: rtl/present80_pkg.sv
// rtl/present80_pkg.sv - PRESENT-80 tables, permutations and key-schedule steps shared by the enc/dec cores
package present80_pkg;

  localparam int NROUNDS = 31;

  // Nibble i of each table holds the substitution for input value i.
  localparam logic [63:0] SBOX_TBL     = 64'h21748FE3DA09B65C;
  localparam logic [63:0] INV_SBOX_TBL = 64'hA970364BD21C8FE5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_KEYEXP,
    ST_WHITEN,
    ST_DEC,
    ST_FINISH
  } dec_state_e;

  typedef enum logic [2:0] {
    KOP_HOLD,
    KOP_LOAD,
    KOP_FWD,
    KOP_INV,
    KOP_CACHE
  } key_op_e;

  function automatic logic [3:0] sbox(input logic [3:0] x);
    return SBOX_TBL[{x, 2'b00} +: 4];
  endfunction

  function automatic logic [3:0] inv_sbox(input logic [3:0] x);
    return INV_SBOX_TBL[{x, 2'b00} +: 4];
  endfunction

  function automatic logic [63:0] sbox_layer(input logic [63:0] s);
    logic [63:0] o;
    for (int n = 0; n < 16; n++) o[4*n +: 4] = sbox(s[4*n +: 4]);
    return o;
  endfunction

  function automatic logic [63:0] inv_sbox_layer(input logic [63:0] s);
    logic [63:0] o;
    for (int n = 0; n < 16; n++) o[4*n +: 4] = inv_sbox(s[4*n +: 4]);
    return o;
  endfunction

  // Bit i moves to position 16*i mod 63; bit 63 stays put.
  function automatic logic [63:0] player(input logic [63:0] s);
    logic [63:0] o;
    o = '0;
    for (int i = 0; i < 63; i++) o[(16*i) % 63] = s[i];
    o[63] = s[63];
    return o;
  endfunction

  function automatic logic [63:0] inv_player(input logic [63:0] s);
    logic [63:0] o;
    o = '0;
    for (int i = 0; i < 63; i++) o[i] = s[(16*i) % 63];
    o[63] = s[63];
    return o;
  endfunction

  function automatic logic [79:0] key_fwd(input logic [79:0] k, input logic [4:0] r);
    logic [79:0] t;
    t          = {k[18:0], k[79:19]};
    t[79:76]   = sbox(t[79:76]);
    t[19:15]   = t[19:15] ^ r;
    return t;
  endfunction

  // Exact inverse of key_fwd for the same round counter.
  function automatic logic [79:0] key_inv(input logic [79:0] k, input logic [4:0] r);
    logic [79:0] t;
    t          = k;
    t[19:15]   = t[19:15] ^ r;
    t[79:76]   = inv_sbox(t[79:76]);
    return {t[60:0], t[79:61]};
  endfunction

endpackage

// File: rtl/present80_dec_core_if.sv
// rtl/present80_dec_core_if.sv - start/busy/done request bus of the PRESENT-80 decryptor
interface present80_dec_core_if;

  logic        start;
  logic        busy;
  logic        done;
  logic [63:0] ct;
  logic [79:0] key;
  logic [63:0] pt;

  modport master (output start, ct, key, input busy, done, pt);
  modport slave  (input start, ct, key, output busy, done, pt);

endinterface

// File: rtl/present80_key_unit.sv
// rtl/present80_key_unit.sv - round-key register with load / forward / inverse steps
// Optional PRESENT80_DEC_KEY_CACHE_EN adds a load of a cached K32.
module present80_key_unit
  import present80_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  key_op_e     op_i,
  input  logic [4:0]  round_i,
  input  logic [79:0] key_i,
`ifdef PRESENT80_DEC_KEY_CACHE_EN
  input  logic [79:0] cache_k32_i,
`endif
  output logic [79:0] round_key_o,
  output logic [79:0] kp_o
);

  logic [79:0] round_key_q;
  logic [79:0] fwd_key;

  assign fwd_key     = key_fwd(round_key_q, round_i);
  assign kp_o        = key_inv(round_key_q, round_i);
  assign round_key_o = round_key_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      round_key_q <= '0;
    end else begin
      case (op_i)
        KOP_LOAD:  round_key_q <= key_i;
        KOP_FWD:   round_key_q <= fwd_key;
        KOP_INV:   round_key_q <= kp_o;
`ifdef PRESENT80_DEC_KEY_CACHE_EN
        KOP_CACHE: round_key_q <= cache_k32_i;
`endif
        default:   round_key_q <= round_key_q;
      endcase
    end
  end

endmodule

// File: rtl/present80_dec_core.sv
// rtl/present80_dec_core.sv - iterative PRESENT-80 decryptor, one round per clock
// Optional PRESENT80_DEC_KEY_CACHE_EN skips key expansion when the key repeats.
module present80_dec_core #(
  parameter int NROUNDS = present80_pkg::NROUNDS
) (
  input  logic                 clk,
  input  logic                 rst,
  present80_dec_core_if.slave  bus
);

  import present80_pkg::*;

  dec_state_e  fsm_q;
  logic [63:0] state_q;
  logic [4:0]  round_q;
  logic        busy_q;
  logic        done_q;
  logic [63:0] pt_q;

  key_op_e     key_op;
  logic [79:0] round_key;
  logic [79:0] kp;
  logic        cache_hit;
  logic        unused_key_bits;

`ifdef PRESENT80_DEC_KEY_CACHE_EN
  logic [79:0] key_q;
  logic [79:0] cache_key_q;
  logic [79:0] cache_k32_q;
  logic        cache_vld_q;

  assign cache_hit = cache_vld_q && (bus.key == cache_key_q);
`else
  assign cache_hit = 1'b0;
`endif

  assign unused_key_bits = ^{round_key[15:0], kp[15:0]};

  always_comb begin
    key_op = KOP_HOLD;
    case (fsm_q)
      ST_IDLE:   if (bus.start) key_op = cache_hit ? KOP_CACHE : KOP_LOAD;
      ST_KEYEXP: key_op = KOP_FWD;
      ST_DEC:    key_op = KOP_INV;
      default:   key_op = KOP_HOLD;
    endcase
  end

  present80_key_unit u_key (
    .clk         (clk),
    .rst         (rst),
    .op_i        (key_op),
    .round_i     (round_q),
    .key_i       (bus.key),
`ifdef PRESENT80_DEC_KEY_CACHE_EN
    .cache_k32_i (cache_k32_q),
`endif
    .round_key_o (round_key),
    .kp_o        (kp)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm_q       <= ST_IDLE;
      state_q     <= '0;
      round_q     <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pt_q        <= '0;
`ifdef PRESENT80_DEC_KEY_CACHE_EN
      key_q       <= '0;
      cache_key_q <= '0;
      cache_k32_q <= '0;
      cache_vld_q <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (fsm_q)
        ST_IDLE: begin
          if (bus.start) begin
            state_q <= bus.ct;
            round_q <= 5'd1;
            busy_q  <= 1'b1;
`ifdef PRESENT80_DEC_KEY_CACHE_EN
            key_q   <= bus.key;
`endif
            fsm_q   <= cache_hit ? ST_WHITEN : ST_KEYEXP;
          end
        end
        ST_KEYEXP: begin
          round_q <= round_q + 5'd1;
          if (round_q == 5'(NROUNDS)) fsm_q <= ST_WHITEN;
        end
        ST_WHITEN: begin
          state_q <= state_q ^ round_key[79:16];
          round_q <= 5'(NROUNDS);
          fsm_q   <= ST_DEC;
`ifdef PRESENT80_DEC_KEY_CACHE_EN
          // On a cache hit these are the values already stored, so refreshing is harmless.
          cache_key_q <= key_q;
          cache_k32_q <= round_key;
          cache_vld_q <= 1'b1;
`endif
        end
        ST_DEC: begin
          state_q <= inv_sbox_layer(inv_player(state_q)) ^ kp[79:16];
          round_q <= round_q - 5'd1;
          if (round_q == 5'd1) fsm_q <= ST_FINISH;
        end
        ST_FINISH: begin
          pt_q   <= state_q;
          done_q <= 1'b1;
          busy_q <= 1'b0;
          fsm_q  <= ST_IDLE;
        end
        default: fsm_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.pt   = pt_q;

endmodule

// File: doc/present80_dec_core.md
Name: present80_dec_core

Overview:
- Iterative PRESENT-80 block decryptor, one round per clock.
- Inverse of the team's PRESENT-80 encryption core: takes a 64-bit ciphertext and an 80-bit key, returns the 64-bit plaintext.
- Uses the same start/busy/done handshake as the encryption core, so both sit side by side under the same crypto controller.
- Decryption needs the last round key first, so each operation has a forward key-expansion phase followed by 31 inverse rounds.

Parameters:
- NROUNDS, 31, number of full rounds; fixed by the PRESENT standard and not intended to change.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  request; sampled only while busy=0
- busy  out  1  high from the start-accept edge until the result edge
- done  out  1  single-cycle pulse, coincident with pt becoming valid
- ct  in  64  ciphertext; latched on start-accept
- key  in  80  key; latched on start-accept
- pt  out  64  plaintext; holds until the next result edge or reset

Behaviour:
- Reset (asynchronous, active-high) clears everything immediately:
  - busy=0, done=0, pt=0.
  - Internal state, round key, round counter and FSM state cleared; FSM goes to IDLE.
- Reset mid-operation aborts the operation; no done pulse is produced.
- FSM states: IDLE, KEYEXP, WHITEN, DEC, FINISH.
- IDLE:
  - On start=1, at edge E0: latch ct into state, latch key into round_key, set round=1, busy=1, go to KEYEXP.
  - start while busy=1 is ignored and not queued.
- KEYEXP (E1..E31):
  - Each edge: round_key <= fwd(round_key, round); round++.
  - fwd step, in order: rotate left 61; S-box on bits [79:76]; XOR round[4:0] into bits [19:15].
  - Leave after round 31; round_key then holds K32.
- WHITEN (E32): state <= state ^ round_key[79:16]; round <= 31.
- DEC (E33..E63), one round per edge, for round = 31 down to 1:
  - kp = inv(round_key, round). inv step, in order: XOR round[4:0] into bits [19:15]; inverse S-box on bits [79:76]; rotate right 61.
  - state <= invS(invP(state)) ^ kp[79:16].
  - round_key <= kp; round--.
  - invP: output bit i = input bit (16*i mod 63) for i = 0..62; bit 63 maps to itself.
  - Leave after round 1.
- FINISH (E64): pt <= state; done=1 for one cycle; busy=0; go to IDLE.
- Latency: start-accept edge to done edge = 64 cycles; 65 cycles per block including the accept edge.
- A new start is accepted in the cycle busy is low, i.e. back-to-back operation from the cycle after done is allowed.
- The done pulse is cleared on every non-FINISH edge.
- ct and key may change after the accept edge without affecting the operation in progress.

Optional Feature:
- Macro: PRESENT80_DEC_KEY_CACHE_EN.
- Defined:
  - Add registers cache_key[79:0], cache_k32[79:0] and cache_vld, all cleared by reset.
  - On the WHITEN edge of a full expansion: store the latched key and K32, set cache_vld=1.
  - On start-accept with cache_vld=1 and key==cache_key: load round_key from cache_k32 and go straight to WHITEN. Latency becomes 33 cycles.
  - A different key takes the normal path and refreshes the cache.
- Not defined: no cache registers; every operation runs KEYEXP; latency is always 64 cycles.

Decomposition:
- Shared package present80_pkg:
  - SBOX and INV_SBOX nibble tables.
  - NROUNDS constant.
  - Bit-permutation functions player and inv_player.
  - Key-step functions key_fwd and key_inv.
  - The encryption core is refactored to import the same package.
- Sub-module present80_key_unit:
  - Owns the round_key register.
  - Ops: load, fwd(r), inv(r), plus cache load when the macro is defined.
  - Exports round_key and kp.
- The datapath stays in the top level.

Test Plan:
- ct=5579C1387B228445, key=0 -> pt=0000000000000000; done exactly 64 cycles after the accept edge; busy high throughout.
- ct=E72C46C0F5945049, key=FFFFFFFFFFFFFFFFFFFF -> pt=0000000000000000. Then ct=3333DCD3213210D2 with the same key -> pt=FFFFFFFFFFFFFFFF. With the cache macro defined, the second operation finishes in 33 cycles.
- ct=A112FFC72F68417B, key=0 -> pt=FFFFFFFFFFFFFFFF.
- Pulse start again at cycle 10 of an operation, and change ct/key mid-operation -> ignored; the result matches the first request; exactly one done pulse.
- Assert rst asynchronously at cycle 40 of an operation -> busy, done and pt drop to 0 before the next clock edge; no done pulse follows; the next start completes correctly.
- Random loop: 1000 random key/pt pairs, encrypt with the encryption core, decrypt with this block -> recovered pt equals the original; done pulses are exactly one cycle wide.
